// File: rtl/router_traffic_monitor.sv
// router_traffic_monitor: taps router flit/credit channels and keeps per-port
// saturating counters, first-header capture and a credit-stall watchdog.
module router_traffic_monitor #(
    parameter int V           = 4,
    parameter int P           = 5,
    parameter int Fpay        = 32,
    parameter int CNTw        = 16,
    parameter int STALL_LIMIT = 64,
    parameter int B           = 4,
    localparam int Fw         = 2 + V + Fpay,
    localparam int OUTw       = $clog2(V * B) + 1,
    localparam int Pw         = (P > 1) ? $clog2(P) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [P*Fw-1:0]   flit_in_all,
    input  logic [P-1:0]      flit_in_we_all,
    input  logic [P*Fw-1:0]   flit_out_all,
    input  logic [P-1:0]      flit_out_we_all,
    input  logic [P*V-1:0]    credit_in_all,
    input  logic              clear,
    input  logic [Pw-1:0]     rd_port,
    input  logic [1:0]        rd_sel,
    output logic [CNTw-1:0]   rd_data,
    output logic [P-1:0]      hdr_valid_all,
    output logic [P-1:0]      stall_alarm_all,
    output logic [P-1:0]      credit_err_all
);

    localparam int HW = (Fpay < CNTw) ? Fpay : CNTw;
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] SLIM = SW'(STALL_LIMIT);

    logic [CNTw-1:0] in_flit_q  [P];
    logic [CNTw-1:0] in_flit_d  [P];
    logic [CNTw-1:0] out_flit_q [P];
    logic [CNTw-1:0] out_flit_d [P];
    logic [CNTw-1:0] in_pck_q   [P];
    logic [CNTw-1:0] in_pck_d   [P];
    logic [CNTw-1:0] hdr_q      [P];
    logic [CNTw-1:0] hdr_d      [P];
    logic [OUTw-1:0] outst_q    [P];
    logic [OUTw-1:0] outst_d    [P];
    logic [SW-1:0]   stall_q    [P];
    logic [SW-1:0]   stall_d    [P];
    logic [P-1:0]    hdr_valid_q, hdr_valid_d;
    logic [P-1:0]    alarm_q, alarm_d;
    logic [P-1:0]    err_q, err_d;
    logic [CNTw-1:0] rd_data_q, rd_data_d;

    // The outgoing flit contents and VC fields are not needed by the monitor.
    logic unused_ok;
    assign unused_ok = ^{flit_out_all, flit_in_all};

    function automatic logic [CNTw-1:0] sat_inc(input logic [CNTw-1:0] c);
        return (c == '1) ? c : c + CNTw'(1);
    endfunction

    always_comb begin
        logic [Fw-1:0]  fin;
        logic [V-1:0]   cr;
        logic [OUTw:0]  pop;
        logic [OUTw:0]  sum;
        logic [OUTw:0]  diff;
        fin = '0;
        cr = '0;
        pop = '0;
        sum = '0;
        diff = '0;
        hdr_valid_d = hdr_valid_q;
        alarm_d = alarm_q;
        err_d = err_q;
        for (int i = 0; i < P; i++) begin
            fin = flit_in_all[i*Fw +: Fw];
            cr = credit_in_all[i*V +: V];
            in_flit_d[i] = in_flit_q[i];
            out_flit_d[i] = out_flit_q[i];
            in_pck_d[i] = in_pck_q[i];
            hdr_d[i] = hdr_q[i];
            if (flit_in_we_all[i]) begin
                in_flit_d[i] = sat_inc(in_flit_q[i]);
                if (fin[Fw-2]) begin
                    in_pck_d[i] = sat_inc(in_pck_q[i]);
                end
                if (fin[Fw-1] && !hdr_valid_q[i]) begin
                    hdr_d[i] = '0;
                    hdr_d[i][HW-1:0] = fin[HW-1:0];
                    hdr_valid_d[i] = 1'b1;
                end
            end
            if (flit_out_we_all[i]) begin
                out_flit_d[i] = sat_inc(out_flit_q[i]);
            end

            // Sent flit and returned credits net out within one cycle.
            pop = '0;
            for (int v = 0; v < V; v++) begin
                pop = pop + (OUTw+1)'(cr[v]);
            end
            sum = {1'b0, outst_q[i]} + (OUTw+1)'(flit_out_we_all[i]);
            diff = sum - pop;
            if (pop > sum) begin
                outst_d[i] = '0;
                err_d[i] = 1'b1;
            end else if (diff[OUTw]) begin
                outst_d[i] = '1;
            end else begin
                outst_d[i] = diff[OUTw-1:0];
            end

            if ((|cr) || (outst_q[i] == '0)) begin
                stall_d[i] = '0;
            end else if (stall_q[i] != SLIM) begin
                stall_d[i] = stall_q[i] + SW'(1);
            end else begin
                stall_d[i] = stall_q[i];
            end
            if (stall_d[i] == SLIM) begin
                alarm_d[i] = 1'b1;
            end
        end

        rd_data_d = '0;
        for (int i = 0; i < P; i++) begin
            if (rd_port == Pw'(i)) begin
                case (rd_sel)
                    2'd0: rd_data_d = in_flit_q[i];
                    2'd1: rd_data_d = out_flit_q[i];
                    2'd2: rd_data_d = in_pck_q[i];
                    2'd3: rd_data_d = hdr_q[i];
                endcase
            end
        end

        if (clear) begin
            for (int i = 0; i < P; i++) begin
                in_flit_d[i] = '0;
                out_flit_d[i] = '0;
                in_pck_d[i] = '0;
                hdr_d[i] = '0;
                outst_d[i] = '0;
                stall_d[i] = '0;
            end
            hdr_valid_d = '0;
            alarm_d = '0;
            err_d = '0;
            rd_data_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < P; i++) begin
                in_flit_q[i] <= '0;
                out_flit_q[i] <= '0;
                in_pck_q[i] <= '0;
                hdr_q[i] <= '0;
                outst_q[i] <= '0;
                stall_q[i] <= '0;
            end
            hdr_valid_q <= '0;
            alarm_q <= '0;
            err_q <= '0;
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < P; i++) begin
                in_flit_q[i] <= in_flit_d[i];
                out_flit_q[i] <= out_flit_d[i];
                in_pck_q[i] <= in_pck_d[i];
                hdr_q[i] <= hdr_d[i];
                outst_q[i] <= outst_d[i];
                stall_q[i] <= stall_d[i];
            end
            hdr_valid_q <= hdr_valid_d;
            alarm_q <= alarm_d;
            err_q <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign hdr_valid_all = hdr_valid_q;
    assign stall_alarm_all = alarm_q;
    assign credit_err_all = err_q;

endmodule
